prio_encoder_q: RTL and testbench
=================================

Name: prio_encoder_q

Overview:
- Parametrised, registered successor to the combinational 4/8/16-bit one-hot encoders.
- Latches request pulses into a pending register and applies a mask.
- Presents one encoded index at a time on a valid/ready output; the handshake clears the granted pending bit.
- Serves as the interrupt/exception source selector ahead of the risc32i control unit.

Parameters:
- N, 16, number of request lines (2..64).
- W, $clog2(N), index width; derived, not overridden.
- HIGH_FIRST, 1, fixed priority direction: 1 = highest index wins, 0 = lowest index wins.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_i  in  N  request bits, pulse or level; OR-ed into pending every cycle
- mask_i  in  N  1 = line blocked from selection; pending bit still retained
- out_ready  in  1  consumer accepts out_idx this cycle
- out_valid  out  1  out_idx holds a selected request
- out_idx  out  W  encoded index of the selected request
- pend_o  out  N  current pending register

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at posedge):
  - pend=0, out_valid=0, out_idx=0, state=IDLE.
  - req_i is ignored in a reset cycle.
  - Reset mid-handshake drops the presented index without clearing any other effect.
- Handshake: hs = out_valid & out_ready. clr = one-hot(out_idx) when hs, else 0.
- Pending update: pend <= (pend & ~clr) | req_i.
  - Set wins over clear on the same bit.
- Eligibility: elig = pend & ~mask_i & ~clr.
  - Uses registered pend only; a req_i bit is not eligible in the cycle it arrives.
- Selection:
  - Priority encode elig per HIGH_FIRST.
  - If elig==0 there is no selection; out_idx is then don't-care and is held.
- FSM:
  - IDLE: if elig!=0, out_idx<=sel, out_valid<=1, go HOLD; else stay.
  - HOLD, hs=0: out_idx and out_valid held stable, even if mask_i later blocks that line or a higher request arrives.
  - HOLD, hs=1, elig!=0: out_idx<=sel, stay HOLD (back-to-back, no bubble).
  - HOLD, hs=1, elig==0: out_valid<=0, go IDLE.
- Latency:
  - req_i at edge t sets pend at t+1.
  - out_valid rises at t+2 from IDLE.
  - Throughput is one grant per cycle.
- All-ones req_i: grants proceed one index per handshake in priority order.
- Zero req_i: out_valid stays 0.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: PRIO_ENC_RR_EN.
- Defined: round-robin priority.
  - A pointer register (W bits, reset to 0) records the last granted index on each hs.
  - HIGH_FIRST=1: search descends starting at (last-1) mod N.
  - HIGH_FIRST=0: search ascends starting at (last+1) mod N.
  - Until the first grant after reset, fixed priority is used.
- Undefined: fixed priority only; no pointer register is instantiated.

Test Plan:
- Reset: hold rst_n=0 two edges with req_i=16'hFFFF -> pend_o=0, out_valid=0, out_idx=0; release -> pend_o=16'hFFFF at the next edge.
- Single pulse: req_i=16'h0020 for one cycle at t, out_ready=1 -> pend_o[5]=1 at t+1; out_valid=1, out_idx=5 at t+2; at t+3 pend_o=0, out_valid=0.
- Back-to-back: req_i=16'h8001 pulse, out_ready=1, HIGH_FIRST=1 -> out_idx 15 then 0 on consecutive cycles, then out_valid=0.
- Mask/stability: pend=16'h0101, mask_i=16'h0100, out_ready=0 -> out_idx=0. Change mask_i to 16'h0001 -> out_idx stays 0 until out_ready=1. Then out_idx=8.
- Set-beats-clear: out_idx=3 valid, out_ready=1, req_i=16'h0008 in the same cycle -> pend_o[3] stays 1. With no other pending bits, out_valid=0 for one cycle, then out_idx=3 again.
- Priority mode: req_i=16'h0007 held, out_ready=1 -> without PRIO_ENC_RR_EN out_idx sequence 2,1,2,1; with PRIO_ENC_RR_EN out_idx sequence 2,1,0,2,1,0.

Source files
------------

// File: rtl/prio_encoder_q.sv
// Registered priority encoder with pending-request latch, mask and valid/ready grant output.
// Optional round-robin arbitration is enabled by defining PRIO_ENC_RR_EN.
module prio_encoder_q #(
  parameter int unsigned N          = 16,
  parameter bit          HIGH_FIRST = 1'b1,
  localparam int unsigned W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   pend_q;
  logic [N-1:0]   pend_d;
  logic [N-1:0]   clr;
  logic [N-1:0]   elig;
  logic           hs;
  logic           any_elig;
  logic [W-1:0]   sel;
  logic [W-1:0]   sel_fix;
  logic [W-1:0]   idx_d;
  logic           valid_d;

  // The granted bit is removed from eligibility in the same cycle so back-to-back grants never repeat it.
  assign hs       = out_valid & out_ready;
  assign clr      = hs ? (N'(1) << out_idx) : '0;
  assign elig     = pend_q & ~mask_i & ~clr;
  assign pend_d   = (pend_q & ~clr) | req_i;
  assign any_elig = |elig;
  assign pend_o   = pend_q;

  // Fixed-priority search: the last hit in scan order wins.
  always_comb begin
    sel_fix = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (elig[i]) sel_fix = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (elig[i]) sel_fix = W'(i);
      end
    end
  end

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr_q;
  logic         seen_q;
  logic [W-1:0] last;
  logic         rr_on;
  logic [W-1:0] sel_rr;
  logic         found;
  int           cand;

  // During a handshake the index being granted is already the most recent grant.
  assign last  = hs ? out_idx : ptr_q;
  assign rr_on = hs | seen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      seen_q <= 1'b0;
    end else if (hs) begin
      ptr_q  <= out_idx;
      seen_q <= 1'b1;
    end
  end

  // Rotating search starting next to the last grant, the last grant itself checked last.
  always_comb begin
    sel_rr = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= int'(N); k++) begin
      if (HIGH_FIRST) cand = (int'(last) + int'(N) - k) % int'(N);
      else            cand = (int'(last) + k) % int'(N);
      if (!found && elig[cand]) begin
        sel_rr = W'(cand);
        found  = 1'b1;
      end
    end
  end

  assign sel = rr_on ? sel_rr : sel_fix;
`else
  assign sel = sel_fix;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    idx_d   = out_idx;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          idx_d   = sel;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          if (any_elig) begin
            idx_d = sel;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      out_valid <= valid_d;
      out_idx   <= idx_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Scoreboard bench for prio_encoder_q (N=16, HIGH_FIRST=1): directed scenarios plus random traffic
// against a cycle-level reference model; honours PRIO_ENC_RR_EN when defined.
module tb_prio_encoder_q;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_i;
  logic [15:0] mask_i;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] pend_o;

  prio_encoder_q #(.N(16), .HIGH_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pend_o    (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] glog[$];

  // Model state as seen after the most recent edge, and its successor.
  logic [15:0] m_pend, n_pend;
  logic        m_valid, n_valid;
  logic [3:0]  m_idx, n_idx;
`ifdef PRIO_ENC_RR_EN
  logic [3:0]  m_ptr, n_ptr;
  bit          m_seen, n_seen;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Highest set bit via arithmetic: floor(log2(e)).
  function automatic logic [3:0] pick_fixed(input logic [15:0] e);
    return 4'($clog2({1'b0, e} + 17'd1) - 1);
  endfunction

`ifdef PRIO_ENC_RR_EN
  function automatic logic [3:0] pick_rr(input logic [15:0] e, input logic [3:0] last);
    for (int k = 1; k <= 16; k++) begin
      int c = (int'(last) + 16 - k) % 16;
      if (e[c]) return 4'(c);
    end
    return 4'd0;
  endfunction
`endif

  task automatic drive(input logic [15:0] r, input logic [15:0] m, input logic rd, input logic rs);
    logic        hsx;
    logic [15:0] clrx;
    logic [15:0] el;
    req_i = r; mask_i = m; out_ready = rd; rst_n = rs;
    n_pend = m_pend; n_valid = m_valid; n_idx = m_idx;
`ifdef PRIO_ENC_RR_EN
    n_ptr = m_ptr; n_seen = m_seen;
`endif
    if (!rs) begin
      n_pend = '0; n_valid = 1'b0; n_idx = '0;
`ifdef PRIO_ENC_RR_EN
      n_ptr = '0; n_seen = 1'b0;
`endif
    end else begin
      hsx    = m_valid && rd;
      clrx   = hsx ? (16'd1 << m_idx) : 16'd0;
      el     = m_pend & ~m & ~clrx;
      n_pend = (m_pend & ~clrx) | r;
      if (hsx) begin
        exp_q.push_back(m_idx);
`ifdef PRIO_ENC_RR_EN
        n_ptr = m_idx; n_seen = 1'b1;
`endif
      end
      if (!m_valid || hsx) begin
        if (el != 16'd0) begin
          n_valid = 1'b1;
`ifdef PRIO_ENC_RR_EN
          n_idx = (hsx || m_seen) ? pick_rr(el, hsx ? m_idx : m_ptr) : pick_fixed(el);
`else
          n_idx = pick_fixed(el);
`endif
        end else begin
          n_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    m_pend = n_pend; m_valid = n_valid; m_idx = n_idx;
`ifdef PRIO_ENC_RR_EN
    m_ptr = n_ptr; m_seen = n_seen;
`endif
    #1;
  endtask

  // Monitor: compares visible state every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (chk) begin
      check("pend", 32'(pend_o), 32'(m_pend));
      check("valid", 32'(out_valid), 32'(m_valid));
      check("idx", 32'(out_idx), 32'(m_idx));
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL grant: unexpected idx %0d, required no grant (t=%0t)", out_idx, $time);
        end else begin
          check("grant", 32'(out_idx), 32'(exp_q.pop_front()));
        end
        glog.push_back(out_idx);
      end
    end
  end

  logic [3:0]  exp_seq[4];
  logic [15:0] rmask;

  initial begin
    rst_n = 1'b0; req_i = '0; mask_i = '0; out_ready = 1'b0;
`ifdef PRIO_ENC_RR_EN
    exp_seq = '{4'd2, 4'd1, 4'd0, 4'd2};
`else
    exp_seq = '{4'd2, 4'd1, 4'd2, 4'd1};
`endif
    // Reset with all requests asserted, then release.
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    chk = 1'b1;
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    check("rst_pend", 32'(pend_o), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_idx", 32'(out_idx), 32'h0);
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    check("rel_pend", 32'(pend_o), 32'hFFFF);

    // All ones drain in priority order.
    glog.delete();
    repeat (18) drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    check("all_cnt", 32'(glog.size()), 32'd16);
    if (glog.size() == 16) begin
      check("all_first", 32'(glog[0]), 32'd15);
      check("all_last", 32'(glog[15]), 32'd0);
    end

    // Single pulse.
    glog.delete();
    drive(16'h0020, 16'h0000, 1'b1, 1'b1);
    repeat (4) drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    check("pulse_cnt", 32'(glog.size()), 32'd1);
    if (glog.size() == 1) check("pulse_idx", 32'(glog[0]), 32'd5);

    // Back-to-back.
    glog.delete();
    drive(16'h8001, 16'h0000, 1'b1, 1'b1);
    repeat (5) drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    check("b2b_cnt", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("b2b_0", 32'(glog[0]), 32'd15);
      check("b2b_1", 32'(glog[1]), 32'd0);
    end

    // Mask and stability while stalled.
    glog.delete();
    drive(16'h0101, 16'h0101, 1'b0, 1'b1);
    drive(16'h0000, 16'h0100, 1'b0, 1'b1);
    drive(16'h0000, 16'h0100, 1'b0, 1'b1);
    check("mask_idx", 32'(out_idx), 32'd0);
    repeat (3) drive(16'h0000, 16'h0001, 1'b0, 1'b1);
    check("hold_idx", 32'(out_idx), 32'd0);
    check("hold_valid", 32'(out_valid), 32'd1);
    repeat (4) drive(16'h0000, 16'h0001, 1'b1, 1'b1);
    check("mask_cnt", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) check("mask_2nd", 32'(glog[1]), 32'd8);

    // Set beats clear on the granted bit.
    drive(16'h0008, 16'h0000, 1'b0, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0, 1'b1);
    drive(16'h0008, 16'h0000, 1'b1, 1'b1);
    check("sbc_pend", 32'(pend_o), 32'h0008);
    check("sbc_bubble", 32'(out_valid), 32'd0);
    drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    check("sbc_again", 32'(out_idx), 32'd3);
    repeat (3) drive(16'h0000, 16'h0000, 1'b1, 1'b1);

    // Priority-mode sequence with held requests.
    glog.delete();
    repeat (6) drive(16'h0007, 16'h0000, 1'b1, 1'b1);
    repeat (6) drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("prio_seq", 32'(glog[i]), 32'(exp_seq[i]));
    end else begin
      check("prio_cnt", 32'(glog.size()), 32'd4);
    end

    // Random traffic, including occasional mid-handshake resets.
    rmask = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) rmask = 16'($urandom) & 16'($urandom);
      drive(16'($urandom) & 16'($urandom) & 16'($urandom), rmask,
            1'($urandom_range(2) != 0), 1'($urandom_range(199) != 0));
    end

    repeat (40) drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    check("drain_q", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
